alu_issue_ctrl: RTL

//  Issue/control front end for the 16-bit combinational ALU: accepts instruction

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_issue_ctrl_if.sv | 29 ++
 rtl/alu_regfile.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/control front end: opcodes, instruction
// field positions and the issue FSM state type.
package alu_pkg;

    localparam int unsigned InstrW = 16;

    // Opcodes, shared with the ALU itself.
    localparam logic [3:0] OpNop  = 4'b0000;
    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpSub  = 4'b0010;
    localparam logic [3:0] OpAsr  = 4'b0011;
    localparam logic [3:0] OpLsl  = 4'b0100;
    localparam logic [3:0] OpLsr  = 4'b0101;
    localparam logic [3:0] OpAnd  = 4'b0110;
    localparam logic [3:0] OpOr   = 4'b0111;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpInv  = 4'b1001;
    localparam logic [3:0] OpMov  = 4'b1010;
    localparam logic [3:0] OpHd   = 4'b1011;
    localparam logic [3:0] OpComp = 4'b1100;

    // Instruction field positions.
    localparam int unsigned OpMsb     = 15;
    localparam int unsigned OpLsb     = 12;
    localparam int unsigned RdMsb     = 11;
    localparam int unsigned RdLsb     = 9;
    localparam int unsigned Rs1Msb    = 8;
    localparam int unsigned Rs1Lsb    = 6;
    localparam int unsigned ImmSelBit = 5;
    localparam int unsigned Rs2Msb    = 4;
    localparam int unsigned Rs2Lsb    = 2;
    localparam int unsigned UseCBit   = 0;
    localparam int unsigned ImmMsb    = 4;
    localparam int unsigned ImmLsb    = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StExec = 2'd2,
        StWb   = 2'd3
    } state_e;

    // Opcodes 1101..1111 are reserved.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return op > OpComp;
    endfunction

    // NOP and illegal ops bypass the ALU entirely.
    function automatic logic op_uses_alu(input logic [3:0] op);
        return (op != OpNop) && !op_is_illegal(op);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and retire signals between the instruction source
// (master) and the issue controller (slave).
interface alu_issue_ctrl_if #(
    parameter int unsigned DATA_W = 16
);

    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic              done;
    logic              illegal;

    modport master (
        output instr_valid,
        output instr_data,
        input  instr_ready,
        input  done,
        input  illegal
    );

    modport slave (
        input  instr_valid,
        input  instr_data,
        output instr_ready,
        output done,
        output illegal
    );

endinterface

// File: rtl/alu_regfile.sv
// 8x16 register file: one synchronous write port, two combinational operand
// read ports and one combinational debug read port; synchronous clear to zero.
module alu_regfile #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0]     rdata1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata2,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int unsigned NumRegs = 1 << REG_ADDR_W;

    logic [DATA_W-1:0] regs_q [NumRegs];

    // Storage: reset wins over a same-cycle write so an aborted retire is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1   = regs_q[raddr1];
    assign rdata2   = regs_q[raddr2];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/control front end for the 16-bit combinational ALU. Accepts one
// instruction at a time, reads operands, drives the ALU for one cycle, then
// writes back the result and latches the status flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned IMM_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_issue_ctrl_if.slave       ctrl,
    output logic [3:0]            alu_op,
    output logic [DATA_W-1:0]     alu_in1,
    output logic [DATA_W-1:0]     alu_in2,
    output logic                  alu_cin,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_eq,
    input  logic                  alu_neg,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic                  flag_n,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    state_e state_q, state_d;

    logic [InstrW-1:0] instr_q;
    logic [DATA_W-1:0] in1_q, in2_q, res_q;
    logic              cin_q;
    logic              hold_c_q, hold_z_q, hold_n_q;
    logic              flag_c_q, flag_z_q, flag_n_q;

    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic                  imm_sel, use_c;
    logic [IMM_W-1:0]      imm5;
    logic [DATA_W-1:0]     imm_ext;
    logic [DATA_W-1:0]     rf_rdata1, rf_rdata2;
    logic                  rf_we;
    logic                  ready, done, illegal;
    logic [3:0]            op_out;

    // Field decode of the captured instruction.
    assign op      = instr_q[OpMsb:OpLsb];
    assign rd      = instr_q[RdMsb:RdLsb];
    assign rs1     = instr_q[Rs1Msb:Rs1Lsb];
    assign rs2     = instr_q[Rs2Msb:Rs2Lsb];
    assign imm_sel = instr_q[ImmSelBit];
    assign use_c   = instr_q[UseCBit];
    assign imm5    = instr_q[ImmMsb:ImmLsb];
    assign imm_ext = {{(DATA_W - IMM_W){1'b0}}, imm5};

    logic unused_instr;
    assign unused_instr = instr_q[1];

    // COMP only updates flags; NOP and illegal ops touch nothing.
    assign rf_we = (state_q == StWb) && op_uses_alu(op) && (op != OpComp);

    alu_regfile #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (res_q),
        .raddr1   (rs1),
        .rdata1   (rf_rdata1),
        .raddr2   (rs2),
        .rdata2   (rf_rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // FSM next-state and per-state outputs.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        op_out  = 4'b0000;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (ctrl.instr_valid) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                state_d = op_uses_alu(op) ? StExec : StWb;
            end
            StExec: begin
                op_out  = op;
                state_d = StWb;
            end
            StWb: begin
                done    = 1'b1;
                illegal = op_is_illegal(op);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction capture on handshake; later instr_data changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= '0;
        end else if ((state_q == StIdle) && ctrl.instr_valid) begin
            instr_q <= ctrl.instr_data;
        end
    end

    // Operand and carry-in registers, loaded while decoding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in1_q <= '0;
            in2_q <= '0;
            cin_q <= 1'b0;
        end else if (state_q == StRead) begin
            in1_q <= rf_rdata1;
            in2_q <= imm_sel ? imm_ext : rf_rdata2;
            cin_q <= (op == OpAdd) && !imm_sel && use_c && flag_c_q;
        end
    end

    // Hold the ALU result and flags at the end of the execute cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q    <= '0;
            hold_c_q <= 1'b0;
            hold_z_q <= 1'b0;
            hold_n_q <= 1'b0;
        end else if (state_q == StExec) begin
            res_q    <= alu_result;
            hold_c_q <= alu_carry;
            hold_z_q <= alu_eq;
            hold_n_q <= alu_neg;
        end
    end

    // Status register, updated on retire of any op that used the ALU.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if ((state_q == StWb) && op_uses_alu(op)) begin
            flag_c_q <= hold_c_q;
            flag_z_q <= hold_z_q;
            flag_n_q <= hold_n_q;
        end
    end

    assign ctrl.instr_ready = ready;
    assign ctrl.done        = done;
    assign ctrl.illegal     = illegal;

    assign alu_op  = op_out;
    assign alu_in1 = in1_q;
    assign alu_in2 = in2_q;
    assign alu_cin = cin_q;
    assign flag_c  = flag_c_q;
    assign flag_z  = flag_z_q;
    assign flag_n  = flag_n_q;

endmodule
